// File: rtl/axi4_ram_if.sv
// AXI4 channel bundle for the on-chip RAM subordinate.
// Valid/ready rule on every channel: a transfer happens on the rising edge where valid and ready are both 1;
// once valid is raised, the sender holds it and its payload unchanged until that edge.
interface axi4_ram_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
);
   logic [ID_WIDTH-1:0]   s_axi_awid;
   logic [ADDR_WIDTH-1:0] s_axi_awaddr;
   logic [7:0]            s_axi_awlen;
   logic [2:0]            s_axi_awsize;
   logic [1:0]            s_axi_awburst;
   logic                  s_axi_awlock;
   logic [3:0]            s_axi_awcache;
   logic [2:0]            s_axi_awprot;
   logic                  s_axi_awvalid;
   logic                  s_axi_awready;

   logic [DATA_WIDTH-1:0] s_axi_wdata;
   logic [STRB_WIDTH-1:0] s_axi_wstrb;
   logic                  s_axi_wlast;
   logic                  s_axi_wvalid;
   logic                  s_axi_wready;

   logic [ID_WIDTH-1:0]   s_axi_bid;
   logic [1:0]            s_axi_bresp;
   logic                  s_axi_bvalid;
   logic                  s_axi_bready;

   logic [ID_WIDTH-1:0]   s_axi_arid;
   logic [ADDR_WIDTH-1:0] s_axi_araddr;
   logic [7:0]            s_axi_arlen;
   logic [2:0]            s_axi_arsize;
   logic [1:0]            s_axi_arburst;
   logic                  s_axi_arlock;
   logic [3:0]            s_axi_arcache;
   logic [2:0]            s_axi_arprot;
   logic                  s_axi_arvalid;
   logic                  s_axi_arready;

   logic [ID_WIDTH-1:0]   s_axi_rid;
   logic [DATA_WIDTH-1:0] s_axi_rdata;
   logic [1:0]            s_axi_rresp;
   logic                  s_axi_rlast;
   logic                  s_axi_rvalid;
   logic                  s_axi_rready;

   modport slave (
      input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
             s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awvalid,
      output s_axi_awready,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
      output s_axi_wready,
      output s_axi_bid, s_axi_bresp, s_axi_bvalid,
      input  s_axi_bready,
      input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
             s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arvalid,
      output s_axi_arready,
      output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
      input  s_axi_rready
   );

   modport master (
      output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
             s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awvalid,
      input  s_axi_awready,
      output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
      input  s_axi_wready,
      input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
      output s_axi_bready,
      output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
             s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arvalid,
      input  s_axi_arready,
      input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
      output s_axi_rready
   );
endinterface

// File: rtl/axi4_ram.sv
// AXI4 subordinate in front of a single-clock RAM; independent write (IDLE/BURST/RESP)
// and read (IDLE/BURST) engines, responses always OKAY.
module axi4_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   axi4_ram_if.slave   s_axi,
   output logic [1:0]  dbg_wr_state,
   output logic        dbg_rd_state
);
   localparam int OFFS  = $clog2(STRB_WIDTH);
   localparam int IDXW  = ADDR_WIDTH - OFFS;
   localparam int DEPTH = 1 << IDXW;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_BURST = 2'd1, W_RESP = 2'd2} wr_state_e;
   typedef enum logic       {R_IDLE = 1'b0, R_BURST = 1'b1} rd_state_e;

   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

   function automatic logic [ADDR_WIDTH-1:0] beat_step(input logic [2:0] size);
      return ADDR_WIDTH'(1) << size;
   endfunction

   // ---------------- write engine ----------------
   wr_state_e             wst_q, wst_d;
   logic [ID_WIDTH-1:0]   bid_q, bid_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
   logic [7:0]            aw_cnt_q, aw_cnt_d;
   logic [2:0]            aw_size_q, aw_size_d;
   logic                  aw_fixed_q, aw_fixed_d;
   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic                  wr_en;
   logic [IDXW-1:0]       wr_idx;

   always_comb begin
      wst_d      = wst_q;
      bid_d      = bid_q;
      aw_addr_d  = aw_addr_q;
      aw_cnt_d   = aw_cnt_q;
      aw_size_d  = aw_size_q;
      aw_fixed_d = aw_fixed_q;
      wr_en      = 1'b0;
      wr_idx     = aw_addr_q[ADDR_WIDTH-1:OFFS];
      case (wst_q)
         W_IDLE: begin
            if (s_axi.s_axi_awvalid && awready_q) begin
               wst_d      = W_BURST;
               bid_d      = s_axi.s_axi_awid;
               aw_addr_d  = s_axi.s_axi_awaddr;
               aw_cnt_d   = s_axi.s_axi_awlen;
               aw_size_d  = s_axi.s_axi_awsize;
               aw_fixed_d = (s_axi.s_axi_awburst == 2'b00);
            end
         end
         W_BURST: begin
            // Remaining-beat count decides the end of the burst; wlast is not trusted.
            if (s_axi.s_axi_wvalid && wready_q) begin
               wr_en = 1'b1;
               if (aw_cnt_q == 8'd0) begin
                  wst_d = W_RESP;
               end else begin
                  aw_cnt_d = aw_cnt_q - 8'd1;
                  if (!aw_fixed_q) aw_addr_d = aw_addr_q + beat_step(aw_size_q);
               end
            end
         end
         W_RESP: begin
            if (bvalid_q && s_axi.s_axi_bready) wst_d = W_IDLE;
         end
         default: wst_d = W_IDLE;
      endcase
      awready_d = (wst_d == W_IDLE);
      wready_d  = (wst_d == W_BURST);
      bvalid_d  = (wst_d == W_RESP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wst_q      <= W_IDLE;
         bid_q      <= '0;
         aw_addr_q  <= '0;
         aw_cnt_q   <= '0;
         aw_size_q  <= '0;
         aw_fixed_q <= 1'b0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
      end else begin
         wst_q      <= wst_d;
         bid_q      <= bid_d;
         aw_addr_q  <= aw_addr_d;
         aw_cnt_q   <= aw_cnt_d;
         aw_size_q  <= aw_size_d;
         aw_fixed_q <= aw_fixed_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            if (s_axi.s_axi_wstrb[b]) mem[wr_idx][b*8 +: 8] <= s_axi.s_axi_wdata[b*8 +: 8];
         end
      end
   end

   // ---------------- read engine ----------------
   rd_state_e             rd_q, rd_d;
   logic [ID_WIDTH-1:0]   rid_q, rid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rlast_q, rlast_d;
   logic                  rvalid_q, rvalid_d;
   logic                  arready_q, arready_d;
   logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
   logic [7:0]            r_cnt_q, r_cnt_d;
   logic [2:0]            r_size_q, r_size_d;
   logic                  r_fixed_q, r_fixed_d;
   logic [IDXW-1:0]       rd_idx;

   // One read port: the AR address while idle, otherwise the next beat's address.
   // The read samples the array before any same-edge write lands, so collisions return old data.
   assign rd_idx = (rd_q == R_IDLE) ? s_axi.s_axi_araddr[ADDR_WIDTH-1:OFFS]
                                    : r_addr_q[ADDR_WIDTH-1:OFFS];

   always_comb begin
      rd_d      = rd_q;
      rid_d     = rid_q;
      rdata_d   = rdata_q;
      rlast_d   = rlast_q;
      r_addr_d  = r_addr_q;
      r_cnt_d   = r_cnt_q;
      r_size_d  = r_size_q;
      r_fixed_d = r_fixed_q;
      case (rd_q)
         R_IDLE: begin
            if (s_axi.s_axi_arvalid && arready_q) begin
               rd_d      = R_BURST;
               rid_d     = s_axi.s_axi_arid;
               rdata_d   = mem[rd_idx];
               rlast_d   = (s_axi.s_axi_arlen == 8'd0);
               r_cnt_d   = s_axi.s_axi_arlen;
               r_size_d  = s_axi.s_axi_arsize;
               r_fixed_d = (s_axi.s_axi_arburst == 2'b00);
               r_addr_d  = (s_axi.s_axi_arburst == 2'b00)
                           ? s_axi.s_axi_araddr
                           : s_axi.s_axi_araddr + beat_step(s_axi.s_axi_arsize);
            end
         end
         R_BURST: begin
            if (rvalid_q && s_axi.s_axi_rready) begin
               if (rlast_q) begin
                  rd_d = R_IDLE;
               end else begin
                  rdata_d = mem[rd_idx];
                  r_cnt_d = r_cnt_q - 8'd1;
                  rlast_d = (r_cnt_q == 8'd1);
                  if (!r_fixed_q) r_addr_d = r_addr_q + beat_step(r_size_q);
               end
            end
         end
         default: rd_d = R_IDLE;
      endcase
      arready_d = (rd_d == R_IDLE);
      rvalid_d  = (rd_d == R_BURST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q      <= R_IDLE;
         rid_q     <= '0;
         rdata_q   <= '0;
         rlast_q   <= 1'b0;
         rvalid_q  <= 1'b0;
         arready_q <= 1'b0;
         r_addr_q  <= '0;
         r_cnt_q   <= '0;
         r_size_q  <= '0;
         r_fixed_q <= 1'b0;
      end else begin
         rd_q      <= rd_d;
         rid_q     <= rid_d;
         rdata_q   <= rdata_d;
         rlast_q   <= rlast_d;
         rvalid_q  <= rvalid_d;
         arready_q <= arready_d;
         r_addr_q  <= r_addr_d;
         r_cnt_q   <= r_cnt_d;
         r_size_q  <= r_size_d;
         r_fixed_q <= r_fixed_d;
      end
   end

   logic unused_ok;
   assign unused_ok = ^{s_axi.s_axi_awlock, s_axi.s_axi_awcache, s_axi.s_axi_awprot,
                        s_axi.s_axi_arlock, s_axi.s_axi_arcache, s_axi.s_axi_arprot,
                        s_axi.s_axi_wlast};

   assign s_axi.s_axi_awready = awready_q;
   assign s_axi.s_axi_wready  = wready_q;
   assign s_axi.s_axi_bid     = bid_q;
   assign s_axi.s_axi_bresp   = 2'b00;
   assign s_axi.s_axi_bvalid  = bvalid_q;
   assign s_axi.s_axi_arready = arready_q;
   assign s_axi.s_axi_rid     = rid_q;
   assign s_axi.s_axi_rdata   = rdata_q;
   assign s_axi.s_axi_rresp   = 2'b00;
   assign s_axi.s_axi_rlast   = rlast_q;
   assign s_axi.s_axi_rvalid  = rvalid_q;
   assign dbg_wr_state        = wst_q;
   assign dbg_rd_state        = rd_q;
endmodule

// File: tb/tb_axi4_ram.sv
// Directed bench for axi4_ram: a table of single-beat write/read vectors plus hand-written
// burst, back-pressure and reset-mid-burst sequences.
module tb_axi4_ram;
   localparam int DW  = 64;
   localparam int AW  = 16;
   localparam int SW  = 8;
   localparam int IW  = 8;
   localparam int LIM = 200;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [1:0] dbg_wr_state;
   logic       dbg_rd_state;

   always #5 clk = ~clk;

   axi4_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) bus();

   axi4_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) dut (
      .clk(clk),
      .rst(rst),
      .s_axi(bus.slave),
      .dbg_wr_state(dbg_wr_state),
      .dbg_rd_state(dbg_rd_state)
   );

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  strb;
      logic [63:0] wdata;
      logic [63:0] exp;
   } vec_t;

   vec_t        vt[6];
   int          n_vec = 0;
   int          n_bad = 0;
   logic [63:0] rbuf[256];
   logic        rlast_buf[256];
   int          rwait[256];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic timed_out(input string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s: no handshake within %0d cycles", name, LIM);
   endtask

   // All driver tasks start and end #1 after a rising edge.
   task automatic aw_send(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int t;
      t = 0;
      bus.s_axi_awid = id; bus.s_axi_awaddr = addr; bus.s_axi_awlen = len;
      bus.s_axi_awsize = size; bus.s_axi_awburst = burst; bus.s_axi_awvalid = 1'b1;
      while (!bus.s_axi_awready && t < LIM) begin @(posedge clk); #1; t++; end
      if (t >= LIM) timed_out("aw_handshake");
      else begin @(posedge clk); #1; end
      bus.s_axi_awvalid = 1'b0;
   endtask

   task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
      int t;
      t = 0;
      bus.s_axi_wdata = data; bus.s_axi_wstrb = strb; bus.s_axi_wlast = last;
      bus.s_axi_wvalid = 1'b1;
      while (!bus.s_axi_wready && t < LIM) begin @(posedge clk); #1; t++; end
      if (t >= LIM) timed_out("w_handshake");
      else begin @(posedge clk); #1; end
      bus.s_axi_wvalid = 1'b0;
   endtask

   task automatic b_take(input logic [7:0] exp_id, input string name);
      int t;
      t = 0;
      bus.s_axi_bready = 1'b1;
      while (!bus.s_axi_bvalid && t < LIM) begin @(posedge clk); #1; t++; end
      if (t >= LIM) timed_out({name, "_b_handshake"});
      else begin
         check({name, "_bid"}, 64'(bus.s_axi_bid), 64'(exp_id));
         check({name, "_bresp"}, 64'(bus.s_axi_bresp), 64'd0);
         @(posedge clk); #1;
      end
      bus.s_axi_bready = 1'b0;
   endtask

   task automatic ar_send(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int t;
      t = 0;
      bus.s_axi_arid = id; bus.s_axi_araddr = addr; bus.s_axi_arlen = len;
      bus.s_axi_arsize = size; bus.s_axi_arburst = burst; bus.s_axi_arvalid = 1'b1;
      while (!bus.s_axi_arready && t < LIM) begin @(posedge clk); #1; t++; end
      if (t >= LIM) timed_out("ar_handshake");
      else begin @(posedge clk); #1; end
      bus.s_axi_arvalid = 1'b0;
   endtask

   task automatic r_take(input logic [7:0] exp_id, input int n, input string name);
      int t;
      bus.s_axi_rready = 1'b1;
      for (int i = 0; i < n; i++) begin
         t = 0;
         while (!bus.s_axi_rvalid && t < LIM) begin @(posedge clk); #1; t++; end
         if (t >= LIM) begin
            timed_out({name, "_r_handshake"});
            break;
         end
         rwait[i]     = t;
         rbuf[i]      = bus.s_axi_rdata;
         rlast_buf[i] = bus.s_axi_rlast;
         check($sformatf("%s_rid%0d", name, i), 64'(bus.s_axi_rid), 64'(exp_id));
         check($sformatf("%s_rresp%0d", name, i), 64'(bus.s_axi_rresp), 64'd0);
         @(posedge clk); #1;
      end
      bus.s_axi_rready = 1'b0;
   endtask

   task automatic check_all_idle_outputs(input string name);
      check({name, "_awready"}, 64'(bus.s_axi_awready), 64'd0);
      check({name, "_wready"},  64'(bus.s_axi_wready),  64'd0);
      check({name, "_bvalid"},  64'(bus.s_axi_bvalid),  64'd0);
      check({name, "_arready"}, 64'(bus.s_axi_arready), 64'd0);
      check({name, "_rvalid"},  64'(bus.s_axi_rvalid),  64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int seen;
      int t;
      bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awsize = '0;
      bus.s_axi_awburst = '0; bus.s_axi_awlock = '0; bus.s_axi_awcache = '0; bus.s_axi_awprot = '0;
      bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
      bus.s_axi_bready = 1'b0;
      bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arsize = '0;
      bus.s_axi_arburst = '0; bus.s_axi_arlock = '0; bus.s_axi_arcache = '0; bus.s_axi_arprot = '0;
      bus.s_axi_arvalid = 1'b0;
      bus.s_axi_rready = 1'b0;

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_idle_outputs("reset");
      check("reset_bid",   64'(bus.s_axi_bid),   64'd0);
      check("reset_rid",   64'(bus.s_axi_rid),   64'd0);
      check("reset_rdata", bus.s_axi_rdata,      64'd0);
      check("reset_rlast", 64'(bus.s_axi_rlast), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_reset_awready", 64'(bus.s_axi_awready), 64'd1);
      check("post_reset_arready", 64'(bus.s_axi_arready), 64'd1);

      // Single-beat table: write, collect B, read back
      vt[0] = '{addr: 16'h0100, strb: 8'hFF, wdata: 64'h1122334455667788, exp: 64'h1122334455667788};
      vt[1] = '{addr: 16'h0100, strb: 8'h0F, wdata: 64'hFFFFFFFFFFFFFFFF, exp: 64'h11223344FFFFFFFF};
      vt[2] = '{addr: 16'h0108, strb: 8'hF0, wdata: 64'hAABBCCDD12345678, exp: 64'hAABBCCDD00000000};
      vt[3] = '{addr: 16'h010F, strb: 8'h01, wdata: 64'h0000000000000099, exp: 64'hAABBCCDD00000099};
      vt[4] = '{addr: 16'h0110, strb: 8'h00, wdata: 64'hFFFFFFFFFFFFFFFF, exp: 64'h0000000000000000};
      vt[5] = '{addr: 16'hFFF8, strb: 8'hFF, wdata: 64'h0123456789ABCDEF, exp: 64'h0123456789ABCDEF};
      for (int i = 0; i < 6; i++) begin
         aw_send(8'(8'h10 + i), vt[i].addr, 8'd0, 3'd3, 2'b01);
         w_send(vt[i].wdata, vt[i].strb, 1'b1);
         b_take(8'(8'h10 + i), $sformatf("vec%0d", i));
         ar_send(8'(8'h40 + i), vt[i].addr, 8'd0, 3'd3, 2'b01);
         r_take(8'(8'h40 + i), 1, $sformatf("vec%0d", i));
         check($sformatf("vec%0d_rdata", i), rbuf[0], vt[i].exp);
         check($sformatf("vec%0d_rlast", i), 64'(rlast_buf[0]), 64'd1);
      end

      // INCR burst, 4 beats at 0x200; wlast deliberately low on all beats
      aw_send(8'h21, 16'h0200, 8'd3, 3'd3, 2'b01);
      for (int i = 0; i < 4; i++) w_send(64'(i + 1), 8'hFF, 1'b0);
      b_take(8'h21, "incr");
      seen = 0;
      repeat (4) begin
         if (bus.s_axi_bvalid) seen++;
         @(posedge clk); #1;
      end
      check("incr_single_b", 64'(seen), 64'd0);
      ar_send(8'h22, 16'h0200, 8'd3, 3'd3, 2'b01);
      r_take(8'h22, 4, "incr");
      for (int i = 0; i < 4; i++) begin
         check($sformatf("incr_rdata%0d", i), rbuf[i], 64'(i + 1));
         check($sformatf("incr_rlast%0d", i), 64'(rlast_buf[i]), (i == 3) ? 64'd1 : 64'd0);
         check($sformatf("incr_rgap%0d", i), 64'(rwait[i]), 64'd0);
      end

      // Narrow INCR read: 4-byte steps stay inside word 0x200
      ar_send(8'h23, 16'h0200, 8'd1, 3'd2, 2'b01);
      r_take(8'h23, 2, "narrow");
      check("narrow_rdata0", rbuf[0], 64'd1);
      check("narrow_rdata1", rbuf[1], 64'd1);
      check("narrow_rlast0", 64'(rlast_buf[0]), 64'd0);
      check("narrow_rlast1", 64'(rlast_buf[1]), 64'd1);

      // WRAP read behaves as INCR
      ar_send(8'h24, 16'h0200, 8'd3, 3'd3, 2'b10);
      r_take(8'h24, 4, "wrap");
      for (int i = 0; i < 4; i++) check($sformatf("wrap_rdata%0d", i), rbuf[i], 64'(i + 1));

      // FIXED write burst: both beats land on 0x300
      aw_send(8'h25, 16'h0300, 8'd1, 3'd3, 2'b00);
      w_send(64'hA, 8'hFF, 1'b0);
      w_send(64'hB, 8'hFF, 1'b1);
      b_take(8'h25, "fixed");
      ar_send(8'h26, 16'h0300, 8'd0, 3'd3, 2'b01);
      r_take(8'h26, 1, "fixed_a");
      check("fixed_rdata_300", rbuf[0], 64'hB);
      ar_send(8'h27, 16'h0308, 8'd0, 3'd3, 2'b01);
      r_take(8'h27, 1, "fixed_b");
      check("fixed_rdata_308", rbuf[0], 64'h0);

      // B back-pressure
      aw_send(8'h28, 16'h0400, 8'd0, 3'd3, 2'b01);
      w_send(64'hCAFE_F00D_0000_0001, 8'hFF, 1'b1);
      t = 0;
      while (!bus.s_axi_bvalid && t < LIM) begin @(posedge clk); #1; t++; end
      if (t >= LIM) timed_out("bp_bvalid");
      for (int c = 0; c < 5; c++) begin
         check($sformatf("bp_bvalid_c%0d", c), 64'(bus.s_axi_bvalid), 64'd1);
         check($sformatf("bp_awready_c%0d", c), 64'(bus.s_axi_awready), 64'd0);
         @(posedge clk); #1;
      end
      b_take(8'h28, "bp");
      check("bp_awready_after", 64'(bus.s_axi_awready), 64'd1);
      check("bp_bvalid_after", 64'(bus.s_axi_bvalid), 64'd0);

      // R stall: each beat held 2 cycles with rready low before being taken
      ar_send(8'h29, 16'h0200, 8'd3, 3'd3, 2'b01);
      for (int i = 0; i < 4; i++) begin
         t = 0;
         while (!bus.s_axi_rvalid && t < LIM) begin @(posedge clk); #1; t++; end
         if (t >= LIM) begin
            timed_out("stall_rvalid");
            break;
         end
         for (int c = 0; c < 2; c++) begin
            check($sformatf("stall_rvalid%0d_%0d", i, c), 64'(bus.s_axi_rvalid), 64'd1);
            check($sformatf("stall_rdata%0d_%0d", i, c), bus.s_axi_rdata, 64'(i + 1));
            check($sformatf("stall_rlast%0d_%0d", i, c), 64'(bus.s_axi_rlast), (i == 3) ? 64'd1 : 64'd0);
            check($sformatf("stall_rid%0d_%0d", i, c), 64'(bus.s_axi_rid), 64'h29);
            @(posedge clk); #1;
         end
         bus.s_axi_rready = 1'b1;
         @(posedge clk); #1;
         bus.s_axi_rready = 1'b0;
      end
      check("stall_rvalid_end", 64'(bus.s_axi_rvalid), 64'd0);

      // Reset after 2 of 4 write beats
      aw_send(8'h30, 16'h0500, 8'd3, 3'd3, 2'b01);
      w_send(64'h55, 8'hFF, 1'b0);
      w_send(64'h66, 8'hFF, 1'b0);
      rst = 1'b1;
      #1;
      check_all_idle_outputs("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      repeat (10) begin
         if (bus.s_axi_bvalid) seen++;
         @(posedge clk); #1;
      end
      check("midrst_no_b", 64'(seen), 64'd0);
      ar_send(8'h31, 16'h0500, 8'd3, 3'd3, 2'b01);
      r_take(8'h31, 4, "midrst");
      check("midrst_rdata0", rbuf[0], 64'h55);
      check("midrst_rdata1", rbuf[1], 64'h66);
      check("midrst_rdata2", rbuf[2], 64'h0);
      check("midrst_rdata3", rbuf[3], 64'h0);
      aw_send(8'h32, 16'h0520, 8'd0, 3'd3, 2'b01);
      w_send(64'h77, 8'hFF, 1'b1);
      b_take(8'h32, "after_rst");
      ar_send(8'h33, 16'h0520, 8'd0, 3'd3, 2'b01);
      r_take(8'h33, 1, "after_rst");
      check("after_rst_rdata", rbuf[0], 64'h77);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
